// File: rtl/lsu_bus_if_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_if_if
// Request/grant/read-valid data bus between the load/store unit and memory.
//
// Signals
//   bus_req    master->slave  access request, held until granted
//   bus_we     master->slave  1 = store, 0 = load
//   bus_addr   master->slave  word-aligned byte address
//   bus_be     master->slave  byte enables, one bit per lane
//   bus_wdata  master->slave  lane-replicated store data
//   bus_gnt    slave->master  request accepted this cycle
//   bus_rvalid slave->master  bus_rdata carries the load word this cycle
//   bus_rdata  slave->master  read word
// ---------------------------------------------------------------------------
interface lsu_bus_if_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_if
// Load/store unit bus interface for the RV32I core. Issues one memory access
// per execute-stage request on a request/grant/read-valid bus, stalls the
// core while the access is in flight, and reports misaligned accesses and
// bus timeouts as flags that accompany the one-cycle done pulse.
//
// Ports
//   clk, rst_n      core clock, asynchronous active-low reset
//   i_mem_req       execute stage requests an access (held until o_done)
//   i_mnemonic      LB/LH/LW/LBU/LHU/SB/SH/SW; anything else is ignored
//   i_addr          effective byte address
//   i_wdata         store data (rs2)
//   bus             bus master side (lsu_bus_if_if.master)
//   o_bus_rddata    load data right-aligned to bit 0 (no extension)
//   o_stall         freeze PC/pipeline (combinational)
//   o_done          one-cycle completion pulse
//   o_misaligned    access was misaligned, valid with o_done
//   o_bus_err       access timed out, valid with o_done
// ---------------------------------------------------------------------------
package lsu_bus_if_pkg;
  typedef enum logic [4:0] {
    NOP, LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, SUB, BEQ, JAL
  } RV32I_INSTRUCTION_MNEMONIC_t;
endpackage

module lsu_bus_if
  import lsu_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_mem_req,
  input  RV32I_INSTRUCTION_MNEMONIC_t i_mnemonic,
  input  logic [31:0]                 i_addr,
  input  logic [31:0]                 i_wdata,
  lsu_bus_if_if.master                bus,
  output logic [31:0]                 o_bus_rddata,
  output logic                        o_stall,
  output logic                        o_done,
  output logic                        o_misaligned,
  output logic                        o_bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // The counter runs through REQ and WAIT; it expires on the cycle that
  // completes TIMEOUT_CYCLES of waiting.
  localparam logic [15:0] L_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_bus_rddata;
  logic [1:0]  r_off;
  logic        r_misaligned;
  logic        r_bus_err;
  logic [15:0] r_cnt;

  logic        w_valid;
  logic        w_load;
  logic        w_half;
  logic        w_word;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic        w_expired;

  logic        w_start;
  logic        w_misal_go;
  logic        w_grant;
  logic        w_rd_take;
  logic        w_timeout;

  // Mnemonic decode: access class, size, alignment, byte enables and the
  // store data replicated across every lane the enables might select.
  always_comb begin
    w_valid = 1'b0;
    w_load  = 1'b0;
    w_half  = 1'b0;
    w_word  = 1'b0;
    case (i_mnemonic)
      LB, LBU: begin w_valid = 1'b1; w_load = 1'b1; end
      LH, LHU: begin w_valid = 1'b1; w_load = 1'b1; w_half = 1'b1; end
      LW:      begin w_valid = 1'b1; w_load = 1'b1; w_word = 1'b1; end
      SB:      begin w_valid = 1'b1; end
      SH:      begin w_valid = 1'b1; w_half = 1'b1; end
      SW:      begin w_valid = 1'b1; w_word = 1'b1; end
      default: ;
    endcase

    w_misal = (w_half & i_addr[0]) | (w_word & (|i_addr[1:0]));

    if (w_load || w_word) begin
      w_be = 4'b1111;
    end else if (w_half) begin
      w_be = 4'b0011 << i_addr[1:0];
    end else begin
      w_be = 4'b0001 << i_addr[1:0];
    end

    if (w_word || w_load) begin
      w_wdata_rep = i_wdata;
    end else if (w_half) begin
      w_wdata_rep = {2{i_wdata[15:0]}};
    end else begin
      w_wdata_rep = {4{i_wdata[7:0]}};
    end
  end

  assign w_expired = (r_cnt >= L_CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic plus one-cycle event strobes for the datapath. A grant
  // or rvalid in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_misal_go = 1'b0;
    w_grant    = 1'b0;
    w_rd_take  = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mem_req && w_valid) begin
          if (w_misal) begin
            w_misal_go = 1'b1;
            w_next     = DONE;
          end else begin
            w_start = 1'b1;
            w_next  = REQ;
          end
        end
      end
      REQ: begin
        if (bus.bus_gnt) begin
          w_grant = 1'b1;
          w_next  = r_bus_we ? DONE : WAIT;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      WAIT: begin
        if (bus.bus_rvalid) begin
          w_rd_take = 1'b1;
          w_next    = DONE;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Bus outputs, flags, load data and timeout counter. The request fields are
  // captured once at the start of an access and held for its whole life so
  // the bus sees stable values; flags persist until the next access starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= 32'd0;
      r_bus_be     <= 4'd0;
      r_bus_wdata  <= 32'd0;
      r_bus_rddata <= 32'd0;
      r_off        <= 2'd0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_cnt        <= 16'd0;
    end else begin
      if (w_start) begin
        r_bus_req    <= 1'b1;
        r_bus_we     <= ~w_load;
        r_bus_addr   <= {i_addr[31:2], 2'b00};
        r_bus_be     <= w_be;
        r_bus_wdata  <= w_wdata_rep;
        r_off        <= i_addr[1:0];
        r_misaligned <= 1'b0;
        r_bus_err    <= 1'b0;
        r_cnt        <= 16'd0;
      end
      if (w_misal_go) begin
        r_misaligned <= 1'b1;
        r_bus_err    <= 1'b0;
      end
      if (r_state == REQ || r_state == WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_grant) begin
        r_bus_req <= 1'b0;
      end
      if (w_rd_take) begin
        r_bus_rddata <= bus.bus_rdata >> {r_off, 3'b000};
      end
      if (w_timeout) begin
        r_bus_req    <= 1'b0;
        r_bus_err    <= 1'b1;
        r_bus_rddata <= 32'd0;
      end
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

  assign o_bus_rddata  = r_bus_rddata;
  assign o_misaligned  = r_misaligned;
  assign o_bus_err     = r_bus_err;
  assign o_done        = (r_state == DONE);
  assign o_stall       = i_mem_req & w_valid & (r_state != DONE);

endmodule

// File: tb/tb_lsu_bus_if.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_if
// Self-checking bench for lsu_bus_if. A procedural bus responder grants and
// returns data after programmable delays; a behavioural model computes the
// expected completion cycle, flags, enables and load data from the access
// rules. The DUT runs with a short timeout so expiry paths are reachable.
// ---------------------------------------------------------------------------
module tb_lsu_bus_if;
  import lsu_bus_if_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic memReq = 1'b0;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic = NOP;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rddata;
  logic stall, done, misaligned, busErr;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;
  logic [31:0] modelRd = '0;

  // Observations recorded by applyStimulus for the calling test.
  int obsDoneCyc, obsReqCyc, obsStallCnt, obsStartCyc, obsDoneAbs;
  logic obsStallAtDone, obsDoneAfter, obsMis, obsErr, obsWe;
  logic [31:0] obsRd, obsAddr, obsWdata;
  logic [3:0] obsBe;

  typedef struct packed {
    int          doneCyc;
    int          reqCyc;
    logic        mis;
    logic        err;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic        we;
    logic [31:0] baddr;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  lsu_bus_if_if busIf ();

  lsu_bus_if #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mem_req    (memReq),
    .i_mnemonic   (mnemonic),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .bus          (busIf),
    .o_bus_rddata (rddata),
    .o_stall      (stall),
    .o_done       (done),
    .o_misaligned (misaligned),
    .o_bus_err    (busErr)
  );

  // Reference model: what an access should do, from the access rules alone.
  // Waiting in REQ+WAIT is limited to T cycles, except that a load granted in
  // the very last cycle still gets one WAIT cycle for its data.
  function automatic exp_t predict(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [31:0] a,
                                   input logic [31:0] wd, input int g, input int r,
                                   input logic [31:0] rdat, input logic [31:0] prevRd);
    exp_t e;
    int size, off, waitBudget;
    bit isLoad;
    isLoad = (mn inside {LB, LH, LW, LBU, LHU});
    size = (mn inside {LB, LBU, SB}) ? 1 : ((mn inside {LH, LHU, SH}) ? 2 : 4);
    off = int'(a[1:0]);
    e.mis = 1'b0;
    e.err = 1'b0;
    e.rd = prevRd;
    e.we = !isLoad;
    e.baddr = {a[31:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      e.be[i] = isLoad || (i >= off && i < off + size);
      e.wdat[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    if (off % size != 0) begin
      e.mis = 1'b1;
      e.doneCyc = 1;
      e.reqCyc = 0;
      return e;
    end
    if (g + 1 > T) begin
      e.err = 1'b1;
      e.rd = '0;
      e.reqCyc = T;
      e.doneCyc = T + 1;
      return e;
    end
    e.reqCyc = g + 1;
    if (!isLoad) begin
      e.doneCyc = g + 2;
      return e;
    end
    waitBudget = (T - (g + 1) > 1) ? T - (g + 1) : 1;
    if (r + 1 <= waitBudget) begin
      e.doneCyc = g + 2 + r + 1;
      e.rd = rdat >> (8 * off);
    end else begin
      e.err = 1'b1;
      e.rd = '0;
      e.doneCyc = g + 2 + waitBudget;
    end
    return e;
  endfunction

  // Drive one access from a negedge in an IDLE cycle (cycle 0) and play the
  // bus slave: grant after gDelay request cycles, rvalid after rDelay wait
  // cycles. Returns at the negedge of the cycle following done.
  task automatic applyStimulus(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [31:0] a,
                               input logic [31:0] wd, input int gDelay, input int rDelay,
                               input logic [31:0] rdat, input bit holdReq);
    int reqSeen, waitSeen;
    bit granted, isLoad, finished;
    isLoad = (mn inside {LB, LH, LW, LBU, LHU});
    reqSeen = 0; waitSeen = 0; granted = 0; finished = 0;
    obsDoneCyc = -1; obsReqCyc = 0; obsStallCnt = 0; obsStallAtDone = 1'b0;
    obsMis = 1'b0; obsErr = 1'b0; obsRd = '0; obsBe = '0; obsAddr = '0; obsWdata = '0; obsWe = 1'b0;
    obsStartCyc = cycleCount; obsDoneAbs = -1;
    memReq = 1'b1; mnemonic = mn; addr = a; wdata = wd;
    for (int c = 0; c < 40 && !finished; c++) begin
      busIf.bus_gnt = 1'b0;
      busIf.bus_rvalid = 1'b0;
      busIf.bus_rdata = $urandom();
      if (busIf.bus_req) begin
        if (obsReqCyc == 0) begin
          obsBe = busIf.bus_be; obsAddr = busIf.bus_addr;
          obsWdata = busIf.bus_wdata; obsWe = busIf.bus_we;
        end
        obsReqCyc++;
        if (reqSeen == gDelay) busIf.bus_gnt = 1'b1;
        reqSeen++;
      end else if (granted && isLoad) begin
        if (waitSeen == rDelay) begin
          busIf.bus_rvalid = 1'b1;
          busIf.bus_rdata = rdat;
        end
        waitSeen++;
      end
      if (busIf.bus_gnt) granted = 1;
      #1;
      if (stall) obsStallCnt++;
      if (done) begin
        obsDoneCyc = c; obsDoneAbs = cycleCount;
        obsMis = misaligned; obsErr = busErr; obsRd = rddata; obsStallAtDone = stall;
        finished = 1;
        if (!holdReq) memReq = 1'b0;
      end
      @(negedge clk);
    end
    busIf.bus_gnt = 1'b0;
    busIf.bus_rvalid = 1'b0;
    if (!holdReq) memReq = 1'b0;
    #1 obsDoneAfter = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    busIf.bus_gnt = 1'b0; busIf.bus_rvalid = 1'b0; busIf.bus_rdata = '0;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({busIf.bus_req, busIf.bus_we, busIf.bus_addr, busIf.bus_be, busIf.bus_wdata} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_bus: got %h, expected 0",
               {busIf.bus_req, busIf.bus_we, busIf.bus_addr, busIf.bus_be, busIf.bus_wdata});
    end
    testsRun++;
    if ({rddata, misaligned, busErr, done, stall} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_core: got %h, expected 0", {rddata, misaligned, busErr, done, stall});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lbu();
    applyStimulus(LBU, 32'h0000_1003, 32'h0, 0, 0, 32'hA1B2_C3D4, 1'b0);
    testsRun++; if (obsAddr !== 32'h1000) begin testsFailed++; $display("[TB] FAIL lbu_addr: got %h, expected 00001000", obsAddr); end
    testsRun++; if (obsBe !== 4'hF) begin testsFailed++; $display("[TB] FAIL lbu_be: got %h, expected f", obsBe); end
    testsRun++; if (obsRd !== 32'h0000_00A1) begin testsFailed++; $display("[TB] FAIL lbu_rddata: got %h, expected 000000a1", obsRd); end
    testsRun++; if (obsDoneCyc != 3) begin testsFailed++; $display("[TB] FAIL lbu_done_cycle: got %0d, expected 3", obsDoneCyc); end
    testsRun++; if (obsStallCnt != 3 || obsStallAtDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL lbu_stall: got %0d/%b, expected 3/0", obsStallCnt, obsStallAtDone); end
    testsRun++; if (obsDoneAfter !== 1'b0) begin testsFailed++; $display("[TB] FAIL lbu_done_width: got %b, expected 0", obsDoneAfter); end
    modelRd = 32'h0000_00A1;
  endtask

  task automatic test_sh_delayed_gnt();
    applyStimulus(SH, 32'h0000_2002, 32'h0000_BEEF, 3, 0, 32'h0, 1'b0);
    testsRun++; if (obsBe !== 4'b1100) begin testsFailed++; $display("[TB] FAIL sh_be: got %b, expected 1100", obsBe); end
    testsRun++; if (obsWdata !== 32'hBEEF_BEEF) begin testsFailed++; $display("[TB] FAIL sh_wdata: got %h, expected beefbeef", obsWdata); end
    testsRun++; if (obsWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL sh_we: got %b, expected 1", obsWe); end
    testsRun++; if (obsReqCyc != 4) begin testsFailed++; $display("[TB] FAIL sh_req_cycles: got %0d, expected 4", obsReqCyc); end
    testsRun++; if (obsDoneCyc != 5) begin testsFailed++; $display("[TB] FAIL sh_done_cycle: got %0d, expected 5", obsDoneCyc); end
    testsRun++; if (obsRd !== modelRd) begin testsFailed++; $display("[TB] FAIL sh_rddata_kept: got %h, expected %h", obsRd, modelRd); end
  endtask

  task automatic test_misaligned();
    applyStimulus(LW, 32'h0000_3001, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b0);
    testsRun++; if (obsReqCyc != 0) begin testsFailed++; $display("[TB] FAIL mis_no_req: got %0d, expected 0", obsReqCyc); end
    testsRun++; if (obsMis !== 1'b1 || obsErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL mis_flags: got %b%b, expected 10", obsMis, obsErr); end
    testsRun++; if (obsDoneCyc != 1) begin testsFailed++; $display("[TB] FAIL mis_done_cycle: got %0d, expected 1", obsDoneCyc); end
    testsRun++; if (obsRd !== modelRd) begin testsFailed++; $display("[TB] FAIL mis_rddata_kept: got %h, expected %h", obsRd, modelRd); end
  endtask

  task automatic test_invalid_mnemonic();
    int bad;
    bad = 0;
    memReq = 1'b1; mnemonic = RV32I_INSTRUCTION_MNEMONIC_t'(5'd9); addr = 32'h44;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (stall !== 1'b0 || done !== 1'b0 || busIf.bus_req !== 1'b0) bad++;
      @(negedge clk);
    end
    memReq = 1'b0;
    testsRun++; if (bad != 0) begin testsFailed++; $display("[TB] FAIL invalid_ignored: got %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_timeout();
    applyStimulus(LW, 32'h0000_0100, 32'h0, 100, 0, 32'h0, 1'b0);
    testsRun++; if (obsReqCyc != T) begin testsFailed++; $display("[TB] FAIL to_req_cycles: got %0d, expected %0d", obsReqCyc, T); end
    testsRun++; if (obsDoneCyc != T + 1) begin testsFailed++; $display("[TB] FAIL to_done_cycle: got %0d, expected %0d", obsDoneCyc, T + 1); end
    testsRun++; if (obsErr !== 1'b1 || obsMis !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_flags: got %b%b, expected 10", obsErr, obsMis); end
    testsRun++; if (obsRd !== 32'h0) begin testsFailed++; $display("[TB] FAIL to_rddata: got %h, expected 0", obsRd); end
    modelRd = '0;
    applyStimulus(SB, 32'h0000_0010, 32'h0000_005A, 0, 0, 32'h0, 1'b0);
    testsRun++; if (obsErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_err_cleared: got %b, expected 0", obsErr); end
    testsRun++; if (obsBe !== 4'b0001 || obsWdata !== 32'h5A5A_5A5A) begin testsFailed++; $display("[TB] FAIL to_sb_lanes: got %b/%h, expected 0001/5a5a5a5a", obsBe, obsWdata); end
  endtask

  task automatic test_back_to_back();
    int firstDone;
    applyStimulus(SW, 32'h0000_0000, 32'hCAFE_F00D, 0, 0, 32'h0, 1'b1);
    firstDone = obsDoneAbs;
    testsRun++; if (obsDoneCyc != 2 || obsWdata !== 32'hCAFE_F00D) begin testsFailed++; $display("[TB] FAIL b2b_sw: got %0d/%h, expected 2/cafef00d", obsDoneCyc, obsWdata); end
    applyStimulus(LH, 32'h0000_0006, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
    testsRun++; if (obsStartCyc != firstDone + 1) begin testsFailed++; $display("[TB] FAIL b2b_start: got %0d, expected %0d", obsStartCyc, firstDone + 1); end
    testsRun++; if (obsDoneCyc != 3) begin testsFailed++; $display("[TB] FAIL b2b_lh_done: got %0d, expected 3", obsDoneCyc); end
    testsRun++; if (obsRd !== 32'h0000_1234 || obsBe !== 4'hF) begin testsFailed++; $display("[TB] FAIL b2b_lh_data: got %h/%h, expected 00001234/f", obsRd, obsBe); end
    testsRun++; if (obsAddr !== 32'h4) begin testsFailed++; $display("[TB] FAIL b2b_lh_addr: got %h, expected 00000004", obsAddr); end
    modelRd = 32'h0000_1234;
  endtask

  task automatic test_reset_mid();
    int doneSeen;
    busIf.bus_gnt = 1'b0; busIf.bus_rvalid = 1'b0;
    memReq = 1'b1; mnemonic = LW; addr = 32'h40;
    @(negedge clk);
    testsRun++; if (busIf.bus_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_in_req: got %b, expected 1", busIf.bus_req); end
    busIf.bus_gnt = 1'b1;
    @(negedge clk);
    busIf.bus_gnt = 1'b0; memReq = 1'b0; rst_n = 1'b0;
    #1;
    testsRun++;
    if ({busIf.bus_req, busIf.bus_we, busIf.bus_addr, busIf.bus_be, busIf.bus_wdata, rddata, misaligned, busErr, done} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_outputs: got %h, expected 0",
               {busIf.bus_req, busIf.bus_we, busIf.bus_addr, busIf.bus_be, busIf.bus_wdata, rddata, misaligned, busErr, done});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); busIf.bus_rvalid = 1'b1; busIf.bus_rdata = 32'hDEAD_BEEF;
    doneSeen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (done) doneSeen++;
      @(negedge clk);
      busIf.bus_rvalid = 1'b0;
    end
    testsRun++; if (doneSeen != 0) begin testsFailed++; $display("[TB] FAIL rstmid_no_done: got %0d, expected 0", doneSeen); end
    testsRun++; if (rddata !== 32'h0 || busIf.bus_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_idle: got %h/%b, expected 0/0", rddata, busIf.bus_req); end
    modelRd = '0;
  endtask

  task automatic test_random();
    RV32I_INSTRUCTION_MNEMONIC_t mns [8];
    RV32I_INSTRUCTION_MNEMONIC_t mn;
    logic [31:0] a, wd, rdat;
    int g, r;
    exp_t e;
    mns = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int n = 0; n < 40; n++) begin
      mn = mns[$urandom_range(0, 7)];
      a = $urandom(); wd = $urandom(); rdat = $urandom();
      g = $urandom_range(0, 4); r = $urandom_range(0, 3);
      e = predict(mn, a, wd, g, r, rdat, modelRd);
      applyStimulus(mn, a, wd, g, r, rdat, 1'b0);
      testsRun++; if (obsDoneCyc != e.doneCyc) begin testsFailed++; $display("[TB] FAIL rnd%0d_done_cycle %s a=%h g=%0d r=%0d: got %0d, expected %0d", n, mn.name(), a, g, r, obsDoneCyc, e.doneCyc); end
      testsRun++; if (obsReqCyc != e.reqCyc) begin testsFailed++; $display("[TB] FAIL rnd%0d_req_cycles: got %0d, expected %0d", n, obsReqCyc, e.reqCyc); end
      testsRun++; if ({obsMis, obsErr} !== {e.mis, e.err}) begin testsFailed++; $display("[TB] FAIL rnd%0d_flags: got %b%b, expected %b%b", n, obsMis, obsErr, e.mis, e.err); end
      testsRun++; if (obsRd !== e.rd) begin testsFailed++; $display("[TB] FAIL rnd%0d_rddata: got %h, expected %h", n, obsRd, e.rd); end
      testsRun++; if (obsStallCnt != e.doneCyc) begin testsFailed++; $display("[TB] FAIL rnd%0d_stall: got %0d, expected %0d", n, obsStallCnt, e.doneCyc); end
      if (!e.mis) begin
        testsRun++; if ({obsAddr, obsBe, obsWe} !== {e.baddr, e.be, e.we}) begin testsFailed++; $display("[TB] FAIL rnd%0d_request: got %h/%b/%b, expected %h/%b/%b", n, obsAddr, obsBe, obsWe, e.baddr, e.be, e.we); end
        if (e.we) begin
          testsRun++; if (obsWdata !== e.wdat) begin testsFailed++; $display("[TB] FAIL rnd%0d_wdata: got %h, expected %h", n, obsWdata, e.wdat); end
        end
      end
      modelRd = e.rd;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_lbu();
    test_sh_delayed_gnt();
    test_misaligned();
    test_invalid_mnemonic();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
